// File: rtl/button_note_scheduler.sv
// Debounces the keypad button index and turns debounced presses/releases into
// an alternating note-on/note-off event stream with a minimum-length gate.
module button_note_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned MIN_GATE_CYCLES = 2000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_on,
  output logic [2:0] evt_note,
  output logic       gate,
  output logic [2:0] active_note,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SEND_ON, HELD, SEND_OFF} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_GATE = CNT_W'(MIN_GATE_CYCLES);
  localparam logic [3:0]       NO_KEY   = 4'd15;

  logic [3:0]       code;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       deb_q;
  logic             deb_is_key;

  state_e           state_q, state_d;
  logic             evt_on_q, evt_on_d;
  logic [2:0]       evt_note_q, evt_note_d;
  logic             gate_q, gate_d;
  logic [2:0]       active_q, active_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  assign code       = (button <= 4'd7) ? button : NO_KEY;
  assign deb_is_key = (deb_q != NO_KEY);

  // The edge that first samples a new code counts as its first stable sample,
  // so deb follows after DEBOUNCE_CYCLES identical samples including that one.
  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= NO_KEY;
      cnt_q  <= '0;
      deb_q  <= NO_KEY;
    end else if (code != cand_q) begin
      cand_q <= code;
      cnt_q  <= '0;
      if (DEBOUNCE_CYCLES == 1) deb_q <= code;
    end else begin
      if (cnt_q != DEB_LAST) cnt_q <= cnt_q + CNT_W'(1);
      if ((cnt_q + CNT_W'(1)) >= DEB_LAST) deb_q <= cand_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      evt_on_q   <= 1'b0;
      evt_note_q <= 3'd0;
      gate_q     <= 1'b0;
      active_q   <= 3'd0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      evt_on_q   <= evt_on_d;
      evt_note_q <= evt_note_d;
      gate_q     <= gate_d;
      active_q   <= active_d;
      gcnt_q     <= gcnt_d;
    end
  end

  // NOTE: every signal gets a hold default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    evt_on_d   = evt_on_q;
    evt_note_d = evt_note_q;
    gate_d     = gate_q;
    active_d   = active_q;
    gcnt_d     = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (deb_is_key) begin
          state_d    = SEND_ON;
          evt_on_d   = 1'b1;
          evt_note_d = deb_q[2:0];
        end
      end
      SEND_ON: begin
        if (evt_ready) begin
          state_d  = HELD;
          gate_d   = 1'b1;
          active_d = evt_note_q;
          gcnt_d   = '0;
        end
      end
      HELD: begin
        if (gcnt_q != '1) gcnt_d = gcnt_q + CNT_W'(1);
        // Switching to another key is treated as releasing the sounding one.
        if ((deb_q != {1'b0, active_q}) && (gcnt_q >= MIN_GATE)) begin
          state_d    = SEND_OFF;
          evt_on_d   = 1'b0;
          evt_note_d = active_q;
        end
      end
      SEND_OFF: begin
        if (evt_ready) begin
          gate_d = 1'b0;
          if (deb_is_key) begin
            state_d    = SEND_ON;
            evt_on_d   = 1'b1;
            evt_note_d = deb_q[2:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt_valid   = (state_q == SEND_ON) || (state_q == SEND_OFF);
    busy        = (state_q != IDLE);
    evt_on      = evt_on_q;
    evt_note    = evt_note_q;
    gate        = gate_q;
    active_note = active_q;
  end

endmodule
